// File: rtl/pmem_scheduler_pkg.sv
// Shared types for the physical-memory scheduler.
// - pmem_owner_t : which requester owns the in-flight adaptor transaction
// - sched_state_t: scheduler FSM states
// - LINE_OFFS_W  : byte-offset bits inside a cache line
// - GNT_*        : bit positions in the request/grant vectors
package pmem_scheduler_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_PF} pmem_owner_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} sched_state_t;

  localparam int unsigned LINE_OFFS_W = 5;

  localparam int unsigned GNT_D  = 0;
  localparam int unsigned GNT_I  = 1;
  localparam int unsigned GNT_PF = 2;

endpackage

// File: rtl/sched_priority_pick.sv
// Combinational arbiter for the pmem scheduler.
// Ports:
//   req     - request vector, indexed by GNT_D / GNT_I / GNT_PF
//   age_sat - icache has lost AGE_MAX times in a row
//   gnt     - one-hot grant (all zero when nothing is requested)
// Order: aged icache, dcache, icache, prefetch.
module sched_priority_pick
  import pmem_scheduler_pkg::*;
(
  input  logic [2:0] req,
  input  logic       age_sat,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (age_sat && req[GNT_I]) begin
      gnt[GNT_I] = 1'b1;
    end else if (req[GNT_D]) begin
      gnt[GNT_D] = 1'b1;
    end else if (req[GNT_I]) begin
      gnt[GNT_I] = 1'b1;
    end else if (req[GNT_PF]) begin
      gnt[GNT_PF] = 1'b1;
    end
  end

endmodule

// File: rtl/pmem_scheduler.sv
// Shares one cacheline_adaptor port between dcache, icache and the next-line prefetcher.
// One request is latched per transaction; the adaptor is driven from the latched copy until
// pmem_resp_c, then the owner's *_resp is pulsed and a one-cycle DONE gap follows.
// Ports:
//   d_pmem_*   - dcache line read/writeback interface
//   i_pmem_*   - icache line read interface
//   pf_*       - prefetcher line read interface
//   pmem_*_c   - cacheline_adaptor side (address line-aligned, strobes registered)
module pmem_scheduler
  import pmem_scheduler_pkg::*;
#(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned OFFS_W  = LINE_OFFS_W,
  parameter int unsigned AGE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              pf_read,
  input  logic [ADDR_W-1:0] pf_address,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  output logic [ADDR_W-1:0] pmem_address_c,
  output logic              pmem_read_c,
  output logic              pmem_write_c,
  output logic [LINE_W-1:0] pmem_wdata_c,
  input  logic [LINE_W-1:0] pmem_rdata_c,
  input  logic              pmem_resp_c
);

  localparam logic [ADDR_W-1:0] OffsMask = ADDR_W'((64'd1 << OFFS_W) - 64'd1);
  localparam logic [2:0]        AgeMax   = 3'(AGE_MAX);

  sched_state_t      state_q, state_d;
  pmem_owner_t       owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [2:0]        age_q, age_d;

  logic [2:0] req, gnt;
  logic       resp_hit;

  always_comb begin
    req         = '0;
    req[GNT_D]  = d_pmem_read | d_pmem_write;
    req[GNT_I]  = i_pmem_read;
    req[GNT_PF] = pf_read;
  end

  sched_priority_pick u_pick (
    .req     (req),
    .age_sat (age_q == AgeMax),
    .gnt     (gnt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    age_d   = age_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt != 3'b000) begin
          state_d = S_BUSY;
          if (gnt[GNT_D]) begin
            owner_d = OWN_D;
            addr_d  = d_pmem_address & ~OffsMask;
            // Write wins if a misbehaving dcache raises both strobes.
            write_d = d_pmem_write;
            read_d  = ~d_pmem_write;
            if (d_pmem_write) wdata_d = d_pmem_wdata;
            if (i_pmem_read && (age_q < AgeMax)) age_d = age_q + 3'd1;
          end else if (gnt[GNT_I]) begin
            owner_d = OWN_I;
            addr_d  = i_pmem_address & ~OffsMask;
            read_d  = 1'b1;
            write_d = 1'b0;
            age_d   = '0;
          end else begin
            owner_d = OWN_PF;
            addr_d  = pf_address & ~OffsMask;
            read_d  = 1'b1;
            write_d = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (pmem_resp_c) begin
          state_d = S_DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      age_q   <= age_d;
    end
  end

  // Resp is combinational so the owner sees it in the same cycle as the adaptor's resp.
  assign resp_hit    = (state_q == S_BUSY) && pmem_resp_c;
  assign d_pmem_resp = resp_hit && (owner_q == OWN_D);
  assign i_pmem_resp = resp_hit && (owner_q == OWN_I);
  assign pf_resp     = resp_hit && (owner_q == OWN_PF);

  assign d_pmem_rdata = pmem_rdata_c;
  assign i_pmem_rdata = pmem_rdata_c;
  assign pf_rdata     = pmem_rdata_c;

  assign pmem_address_c = addr_q;
  assign pmem_read_c    = read_q;
  assign pmem_write_c   = write_q;
  assign pmem_wdata_c   = wdata_q;

endmodule

// File: tb/tb_pmem_scheduler.sv
module tb_pmem_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         d_pmem_read, d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic         d_pmem_resp;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         pf_read;
  logic [31:0]  pf_address;
  logic [255:0] pf_rdata;
  logic         pf_resp;
  logic [31:0]  pmem_address_c;
  logic         pmem_read_c, pmem_write_c;
  logic [255:0] pmem_wdata_c, pmem_rdata_c;
  logic         pmem_resp_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .pf_read        (pf_read),
    .pf_address     (pf_address),
    .pf_rdata       (pf_rdata),
    .pf_resp        (pf_resp),
    .pmem_address_c (pmem_address_c),
    .pmem_read_c    (pmem_read_c),
    .pmem_write_c   (pmem_write_c),
    .pmem_wdata_c   (pmem_wdata_c),
    .pmem_rdata_c   (pmem_rdata_c),
    .pmem_resp_c    (pmem_resp_c)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an adaptor strobe, then checks the issued transaction.
  task automatic wait_grant(input string tag, input logic [31:0] exp_addr, input logic exp_rd,
                            input logic exp_wr, output int cyc);
    cyc = 0;
    while (!(pmem_read_c || pmem_write_c) && cyc < 30) begin
      tick();
      cyc++;
    end
    check({tag, "_strobe"}, 256'(pmem_read_c | pmem_write_c), 256'(1));
    check({tag, "_addr"}, 256'(pmem_address_c), 256'(exp_addr));
    check({tag, "_rd"}, 256'(pmem_read_c), 256'(exp_rd));
    check({tag, "_wr"}, 256'(pmem_write_c), 256'(exp_wr));
  endtask

  // Adaptor answers; owner 0=dcache 1=icache 2=prefetch. Returns in the DONE cycle.
  task automatic respond(input string tag, input int owner, input logic [255:0] data);
    logic [255:0] seen;
    pmem_rdata_c = data;
    pmem_resp_c  = 1'b1;
    #1;
    check({tag, "_dresp"}, 256'(d_pmem_resp), 256'(owner == 0));
    check({tag, "_iresp"}, 256'(i_pmem_resp), 256'(owner == 1));
    check({tag, "_pfresp"}, 256'(pf_resp), 256'(owner == 2));
    seen = (owner == 0) ? d_pmem_rdata : (owner == 1) ? i_pmem_rdata : pf_rdata;
    check({tag, "_rdata"}, seen, data);
    tick();
    pmem_resp_c  = 1'b0;
    pmem_rdata_c = '0;
    #1;
    check({tag, "_done_strobe"}, 256'(pmem_read_c | pmem_write_c), 256'(0));
    check({tag, "_done_resp"}, 256'(d_pmem_resp | i_pmem_resp | pf_resp), 256'(0));
  endtask

  initial begin
    int cyc;
    logic [255:0] line_ab, line_de, line_12;
    line_ab = {32{8'hAB}};
    line_de = {8{32'hDEADBEEF}};
    line_12 = {8{32'h12345678}};

    rst = 1'b1;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    i_pmem_read = 0; i_pmem_address = '0; pf_read = 0; pf_address = '0;
    pmem_rdata_c = '0; pmem_resp_c = 0;
    #12;
    check("rst_strobes", 256'(pmem_read_c | pmem_write_c), 256'(0));
    check("rst_resps", 256'(d_pmem_resp | i_pmem_resp | pf_resp), 256'(0));
    check("rst_addr", 256'(pmem_address_c), 256'(0));
    check("rst_wdata", pmem_wdata_c, 256'(0));
    tick();
    rst = 1'b0;
    tick();

    // Lone icache read, offset bits stripped, strobe one cycle after the request.
    i_pmem_read = 1; i_pmem_address = 32'h0000_0064;
    wait_grant("t1", 32'h0000_0060, 1'b1, 1'b0, cyc);
    check("t1_latency", 256'(cyc), 256'(1));
    repeat (10) tick();
    check("t1_hold", 256'(pmem_read_c), 256'(1));
    respond("t1", 1, line_ab);
    i_pmem_read = 0;

    // Simultaneous icache/dcache: dcache first, icache after the DONE gap.
    i_pmem_read = 1; i_pmem_address = 32'h100;
    d_pmem_read = 1; d_pmem_address = 32'h200;
    wait_grant("t2d", 32'h200, 1'b1, 1'b0, cyc);
    repeat (2) tick();
    respond("t2d", 0, 256'h11);
    d_pmem_read = 0;
    wait_grant("t2i", 32'h100, 1'b1, 1'b0, cyc);
    check("t2_gap", 256'(cyc), 256'(2));
    respond("t2i", 1, 256'h22);
    i_pmem_read = 0;

    // Aging: four dcache wins, then the held icache request overrides.
    i_pmem_read = 1; i_pmem_address = 32'h3000;
    d_pmem_read = 1; d_pmem_address = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("t3d%0d", k), 32'h1000 + 32'(k) * 32'h20, 1'b1, 1'b0, cyc);
      respond($sformatf("t3d%0d", k), 0, 256'(k));
      d_pmem_address = 32'h1000 + 32'(k + 1) * 32'h20;
    end
    wait_grant("t3i", 32'h3000, 1'b1, 1'b0, cyc);
    respond("t3i", 1, 256'h33);
    i_pmem_read = 0;
    wait_grant("t3d4", 32'h1080, 1'b1, 1'b0, cyc);
    respond("t3d4", 0, 256'h44);
    // Age cleared by the icache grant: dcache wins again.
    d_pmem_address = 32'h1100; i_pmem_read = 1; i_pmem_address = 32'h3020;
    wait_grant("t3age_d", 32'h1100, 1'b1, 1'b0, cyc);
    respond("t3age_d", 0, 256'h55);
    d_pmem_read = 0;
    wait_grant("t3age_i", 32'h3020, 1'b1, 1'b0, cyc);
    respond("t3age_i", 1, 256'h66);
    i_pmem_read = 0;

    // Writeback: wdata latched at grant, later input changes ignored.
    d_pmem_write = 1; d_pmem_address = 32'h0000_1040; d_pmem_wdata = line_de;
    wait_grant("t4", 32'h0000_1040, 1'b0, 1'b1, cyc);
    check("t4_wdata", pmem_wdata_c, line_de);
    d_pmem_wdata = line_12; d_pmem_address = 32'h7000;
    repeat (3) tick();
    check("t4_wdata_hold", pmem_wdata_c, line_de);
    check("t4_addr_hold", 256'(pmem_address_c), 256'(32'h1040));
    respond("t4", 0, 256'h0);
    d_pmem_write = 0;

    // Prefetch alone.
    pf_read = 1; pf_address = 32'h8044;
    wait_grant("t5pf", 32'h8040, 1'b1, 1'b0, cyc);
    respond("t5pf", 2, 256'h77);
    pf_read = 0;
    tick();
    // Prefetch with dcache: dcache first.
    pf_read = 1; pf_address = 32'h9000;
    d_pmem_read = 1; d_pmem_address = 32'hA000;
    wait_grant("t5d", 32'hA000, 1'b1, 1'b0, cyc);
    respond("t5d", 0, 256'h88);
    d_pmem_read = 0;
    wait_grant("t5pf2", 32'h9000, 1'b1, 1'b0, cyc);
    respond("t5pf2", 2, 256'h99);
    pf_read = 0;
    // Prefetch dropped while dcache owns the port: never issued.
    pf_read = 1; pf_address = 32'hB000;
    d_pmem_read = 1; d_pmem_address = 32'hC000;
    wait_grant("t5d2", 32'hC000, 1'b1, 1'b0, cyc);
    pf_read = 0;
    respond("t5d2", 0, 256'hAA);
    d_pmem_read = 0;
    repeat (5) tick();
    check("t5_pf_vanish", 256'(pmem_read_c | pmem_write_c), 256'(0));

    // Asynchronous reset mid-BUSY.
    i_pmem_read = 1; i_pmem_address = 32'h5000;
    wait_grant("t6", 32'h5000, 1'b1, 1'b0, cyc);
    tick();
    #2;
    rst = 1'b1;
    pmem_resp_c = 1'b1;
    #1;
    check("t6_rst_strobe", 256'(pmem_read_c | pmem_write_c), 256'(0));
    check("t6_rst_resp", 256'(d_pmem_resp | i_pmem_resp | pf_resp), 256'(0));
    pmem_resp_c = 1'b0;
    i_pmem_address = 32'h6000;
    tick();
    rst = 1'b0;
    wait_grant("t6new", 32'h6000, 1'b1, 1'b0, cyc);
    check("t6_latency", 256'(cyc), 256'(1));
    respond("t6new", 1, 256'hBB);
    i_pmem_read = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_scheduler.md
Name: pmem_scheduler

Overview:
- Shares the single cacheline_adaptor port (256-bit line interface) between three line-level requesters: dcache, icache and a next-line instruction prefetcher.
- Sits between the caches/prefetcher and cacheline_adaptor in mp4.
- Latches one request per transaction, drives the adaptor until its response arrives, then routes the response to the owner.
- Fixed priority with an aging override so the icache cannot starve under heavy dcache traffic.

Parameters:
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, address width
- OFFS_W, 5, line offset bits; these are zeroed on the forwarded address
- AGE_MAX, 4, consecutive losses by a pending icache request before it overrides dcache priority

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- d_pmem_read  in  1  dcache line read request
- d_pmem_write  in  1  dcache line writeback request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache writeback line
- d_pmem_rdata  out  LINE_W  line returned to dcache
- d_pmem_resp  out  1  dcache transaction done
- i_pmem_read  in  1  icache line read request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_rdata  out  LINE_W  line returned to icache
- i_pmem_resp  out  1  icache transaction done
- pf_read  in  1  prefetch line read request
- pf_address  in  ADDR_W  prefetch line address
- pf_rdata  out  LINE_W  prefetched line
- pf_resp  out  1  prefetch done
- pmem_address_c  out  ADDR_W  adaptor address, line-aligned
- pmem_read_c  out  1  adaptor read strobe
- pmem_write_c  out  1  adaptor write strobe
- pmem_wdata_c  out  LINE_W  adaptor write line
- pmem_rdata_c  in  LINE_W  adaptor read line
- pmem_resp_c  in  1  adaptor done

Behaviour:
- Reset: all outputs 0, FSM=IDLE, age counter=0, owner=NONE. Reset is asynchronous; asserting it mid-transaction abandons the transaction immediately. cacheline_adaptor is reset by the same rst.
- FSM states: IDLE, BUSY, DONE.
- IDLE: evaluate requests in order (1) icache if age==AGE_MAX and i_pmem_read; (2) dcache (read or write); (3) icache; (4) prefetch.
  - On a grant, register owner, address with [OFFS_W-1:0] forced to 0, the op, and wdata (dcache write only). Go to BUSY.
  - No request: stay in IDLE.
- BUSY: pmem_read_c/pmem_write_c are registered and held high for the whole state. Address and wdata come from the latched copy, so requester changes mid-transaction are ignored.
  - On pmem_resp_c=1: drop the strobes on the next edge, pulse the owner's *_resp combinationally in the same cycle, and go to DONE.
- DONE: one cycle, no strobes, no new grant, so the owner can deassert its request. Then go to IDLE.
- Timing: request seen in IDLE at cycle N → strobe high at N+1. Back-to-back grants are spaced at least 2 cycles after resp.
- Response routing: pmem_rdata_c is broadcast to all three *_rdata outputs. Only the owner's resp is ever asserted; the others stay 0. pmem_resp_c outside BUSY is ignored.
- Dcache read and write both high: write takes precedence; this is illegal per the cache contract.
- Age counter (3-bit saturating):
  - Increments each time an IDLE grant goes to dcache while i_pmem_read=1.
  - Clears when icache is granted.
  - Saturates at AGE_MAX.
- Prefetch: lowest priority and never ages. If pf_read drops while not granted, the request simply vanishes. Once granted, it completes normally.
- Owner hold rule: requesters hold request/address until their resp. The scheduler does not require this in BUSY, because values are latched.

Decomposition:
- Shared package rv32i_types gains the following:
  - enum pmem_owner_t {OWN_NONE, OWN_D, OWN_I, OWN_PF}
  - enum sched_state_t {S_IDLE, S_BUSY, S_DONE}
  - localparam LINE_OFFS_W=5
- One natural sub-module: sched_priority_pick. It is combinational and takes the request vector plus the age-saturated flag, returning a one-hot grant. The FSM and registers stay in pmem_scheduler.

Test Plan:
- Lone icache read of 0x0000_0064 → pmem_address_c=0x0000_0060, pmem_read_c high at N+1. Adaptor resp after 10 cycles with rdata=0xAB..AB → i_pmem_resp pulse with that data; d_pmem_resp and pf_resp stay 0.
- i_pmem_read and d_pmem_read asserted in the same cycle (0x100 and 0x200) → dcache granted first (address 0x200). After DONE, icache granted (0x100).
- dcache issues 5 back-to-back reads while i_pmem_read is held → icache is granted after exactly 4 dcache grants; age resets to 0.
- dcache write at 0x0000_1040 with wdata=0xDEADBEEF repeated, and the wdata input changed mid-BUSY → pmem_write_c=1, pmem_wdata_c holds the original value until resp.
- pf_read alone → granted. pf_read together with d_pmem_read → dcache first. pf_read dropped before grant → no prefetch transaction is issued.
- rst asserted in the middle of BUSY → pmem_read_c, pmem_write_c and all *_resp go to 0 asynchronously. After release, FSM=IDLE and a new icache request is granted normally.
